// File: rtl/burst_ctrl.sv
// Burst controller in front of an n-bit up-counter: presets the counter so its
// carry-out flags the final beat, paces beats over valid/ready, pulses done.
module burst_ctrl #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] len,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         in_last,
  output logic         busy,
  output logic         done,
  output logic         cnt_ld,
  output logic         cnt_en,
  output logic [N-1:0] cnt_init,
  input  logic         cnt_co
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_init_q, cnt_init_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_init_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_init_q <= cnt_init_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_init_d = cnt_init_q;
    in_ready   = 1'b0;
    in_last    = 1'b0;
    done       = 1'b0;
    cnt_ld     = 1'b0;
    cnt_en     = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // Two's complement preset: carry-out rises after len-1 increments.
        if (start) begin
          cnt_init_d = -len;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        cnt_ld  = 1'b1;
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          in_ready = 1'b1;
          cnt_en   = in_valid;
          in_last  = in_valid & cnt_co;
          if (in_valid & cnt_co) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_init = cnt_init_q;

endmodule

// File: tb/tb_burst_ctrl.sv
// Scoreboard bench for burst_ctrl with a behavioural model of the downstream
// up-counter; stimulus pushes expected beats/done, a monitor pops and compares.
module tb_burst_ctrl;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort, in_valid;
  logic [N-1:0] len;
  logic         in_ready, in_last, busy, done, cnt_ld, cnt_en, cnt_co;
  logic [N-1:0] cnt_init;
  logic [N-1:0] cnt_model;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

  typedef struct {
    bit is_done;
    bit last;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  burst_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .busy(busy), .done(done), .cnt_ld(cnt_ld), .cnt_en(cnt_en),
    .cnt_init(cnt_init), .cnt_co(cnt_co)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream counter: load, increment, carry-out when all ones.
  always @(posedge clk) begin
    if (cnt_ld) cnt_model <= cnt_init;
    else if (cnt_en) cnt_model <= cnt_model + 1'b1;
  end
  assign cnt_co = &cnt_model;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every accepted beat and every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (rst) begin
      chk("en_is_handshake", int'(cnt_en), int'(in_valid & in_ready));
      if (cnt_en) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_kind", int'(e.is_done), 0);
          chk("beat_cycle", cyc, e.cyc);
          chk("beat_last", int'(in_last), int'(e.last));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_kind", int'(e.is_done), 1);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // gap bit r-1 set => in_valid low on RUN cycle r; abort_at 0 = in LOAD, -1 = never.
  task automatic burst(input logic [N-1:0] l, input int nbeats, input logic [31:0] gap,
                       input int abort_at, input bit poke);
    int got;
    int exp_init;
    exp_init = ((1 << N) - int'(l)) % (1 << N);
    got = 0;
    @(posedge clk); #1;
    start = 1'b1; len = l;
    @(negedge clk);
    chk("idle_before_start", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0; len = ~l;
    abort = (abort_at == 0);
    @(negedge clk);
    chk("load_cnt_ld", int'(cnt_ld), 1);
    chk("load_cnt_init", int'(cnt_init), exp_init);
    if (abort_at == 0) begin
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("load_abort_idle", int'(busy), 0);
      return;
    end
    for (int r = 1; r <= nbeats + 40; r++) begin
      @(posedge clk); #1;
      start    = poke && (r == 2);
      len      = (poke && r == 2) ? (l ^ 6'h2A) : l;
      in_valid = (r <= 32) ? !gap[r-1] : 1'b1;
      abort    = (r == abort_at);
      if (abort) begin
        in_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("run_abort_idle", int'(busy), 0);
        chk("run_abort_no_done", int'(done), 0);
        return;
      end
      if (in_valid) begin
        got++;
        exp_q.push_back('{is_done: 1'b0, last: (got == nbeats), cyc: cyc});
      end
      if (got == nbeats) begin
        exp_q.push_back('{is_done: 1'b1, last: 1'b0, cyc: cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = poke;
        len      = l ^ 6'h15;
        @(negedge clk);
        chk("done_ready_low", int'(in_ready), 0);
        chk("init_held", int'(cnt_init), exp_init);
        start = 1'b0;
        return;
      end
    end
    chk("burst_overrun", got, nbeats);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; len = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ld", int'(cnt_ld), 0);
    chk("rst_init", int'(cnt_init), 0);
    #2 rst = 1'b1;

    burst(6'd5, 5, 32'h0, -1, 1'b0);       // gapless
    burst(6'd1, 1, 32'h0, -1, 1'b0);       // single beat, back-to-back start
    burst(6'd0, 64, 32'h0, -1, 1'b0);      // full 2^N burst
    burst(6'd4, 4, 32'h26, -1, 1'b0);      // valid 1,0,0,1,1,0,1
    burst(6'd10, 10, 32'h0, 2, 1'b0);      // abort in 2nd RUN cycle
    burst(6'd3, 3, 32'h0, 0, 1'b0);        // abort in LOAD
    burst(6'd5, 5, 32'h0, -1, 1'b1);       // start pokes in RUN and DONE
    burst(6'd2, 2, 32'h0, -1, 1'b0);       // start right after poked DONE

    // Reset mid-burst: three beats in, then asynchronous reset between edges.
    @(posedge clk); #1;
    start = 1'b1; len = 6'd10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      exp_q.push_back('{is_done: 1'b0, last: 1'b0, cyc: cyc});
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_en", int'(cnt_en), 0);
    chk("mid_rst_last", int'(in_last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ld", int'(cnt_ld), 0);
    chk("mid_rst_init", int'(cnt_init), 0);
    @(negedge clk); #2;
    rst = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("post_rst_idle", int'(busy), 0);
      chk("post_rst_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;

    burst(6'd1, 1, 32'h0, -1, 1'b0);       // new start honored after reset
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
